// File: rtl/gauss_coeff_loader_pkg.sv
// Shared constants, FSM state type and row-sum helper for the Gaussian coefficient loader.
package gauss_pkg;

  localparam int unsigned ROWS   = 5;
  localparam int unsigned COLS   = 5;
  localparam int unsigned CW     = 8;
  localparam int unsigned SUM_W  = 13;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned WORD_W = COLS * CW;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    DONE
  } state_t;

  function automatic logic [SUM_W-1:0] row_sum(input logic [WORD_W-1:0] word);
    logic [SUM_W-1:0] s;
    s = '0;
    for (int unsigned c = 0; c < COLS; c++) begin
      s = s + SUM_W'(word[c*CW +: CW]);
    end
    return s;
  endfunction

endpackage

// File: rtl/gauss_coeff_loader_if.sv
// ROM read bus between the coefficient loader (master) and rom5x5 (slave).
interface gauss_coeff_loader_if #(
  parameter int unsigned DW = gauss_pkg::WORD_W
);

  logic                        rom_rd_en;
  logic [gauss_pkg::ADDR_W-1:0] rom_addr;
  logic [DW-1:0]               rom_data;

  modport master (output rom_rd_en, output rom_addr, input rom_data);
  modport slave  (input rom_rd_en, input rom_addr, output rom_data);

endinterface

// File: rtl/gauss_coeff_loader_row_unpack.sv
// Splits one ROM word into its columns (MSB byte = column 0) and gives the row sum.
module gauss_row_unpack
  import gauss_pkg::*;
(
  input  logic [WORD_W-1:0]        word,
  output logic [COLS-1:0][CW-1:0]  cols,
  output logic [SUM_W-1:0]         sum
);

  always_comb begin
    cols = '0;
    for (int unsigned c = 0; c < COLS; c++) begin
      cols[c] = word[(COLS-1-c)*CW +: CW];
    end
  end

  assign sum = row_sum(word);

endmodule

// File: rtl/gauss_coeff_loader.sv
// Reads the 5x5 Gaussian ROM row by row into a flat coefficient bank and
// accumulates the kernel sum for the normalisation stage.
module gauss_coeff_loader
  import gauss_pkg::*;
#(
  parameter int unsigned ROM_LAT   = 1,
  parameter bit          AUTO_LOAD = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     coeff_valid,
  gauss_coeff_loader_if.master     rom,
  output logic [ROWS*COLS*CW-1:0]  coeff_flat,
  output logic [SUM_W-1:0]         coeff_sum
);

  state_t                  state;
  logic                    first;
  logic                    go;
  logic                    cap;
  logic [ADDR_W-1:0]       cap_row;
  logic [ROM_LAT-1:0]      lag_vld;
  logic [ADDR_W-1:0]       lag_row [ROM_LAT];
  logic [SUM_W-1:0]        acc;
  logic [COLS-1:0][CW-1:0] cap_cols;
  logic [SUM_W-1:0]        cap_sum;

  // first is only high in the first cycle after reset release
  assign go      = (state == IDLE) && (start || (AUTO_LOAD && first));
  assign cap     = lag_vld[ROM_LAT-1];
  assign cap_row = lag_row[ROM_LAT-1];

  gauss_row_unpack u_unpack (
    .word (rom.rom_data),
    .cols (cap_cols),
    .sum  (cap_sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      first         <= 1'b1;
      busy          <= 1'b0;
      done          <= 1'b0;
      coeff_valid   <= 1'b0;
      coeff_sum     <= '0;
      rom.rom_rd_en <= 1'b0;
      rom.rom_addr  <= '0;
    end else begin
      first <= 1'b0;
      case (state)
        IDLE: begin
          if (go) begin
            state         <= FETCH;
            busy          <= 1'b1;
            coeff_valid   <= 1'b0;
            rom.rom_rd_en <= 1'b1;
            rom.rom_addr  <= '0;
          end
        end
        FETCH: begin
          if (rom.rom_addr == ADDR_W'(ROWS-1)) begin
            state         <= DRAIN;
            rom.rom_rd_en <= 1'b0;
          end else begin
            rom.rom_addr <= rom.rom_addr + ADDR_W'(1);
          end
        end
        // leave DRAIN exactly when the last row emerges from the lag pipe
        DRAIN: begin
          if (cap && (cap_row == ADDR_W'(ROWS-1))) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state       <= IDLE;
          done        <= 1'b0;
          coeff_valid <= 1'b1;
          coeff_sum   <= acc;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lag_vld    <= '0;
      acc        <= '0;
      coeff_flat <= '0;
      for (int unsigned i = 0; i < ROM_LAT; i++) begin
        lag_row[i] <= '0;
      end
    end else begin
      lag_vld[0] <= rom.rom_rd_en;
      lag_row[0] <= rom.rom_addr;
      for (int unsigned i = 1; i < ROM_LAT; i++) begin
        lag_vld[i] <= lag_vld[i-1];
        lag_row[i] <= lag_row[i-1];
      end

      if (go) begin
        acc <= '0;
      end else if (cap) begin
        acc <= acc + cap_sum;
      end

      for (int unsigned r = 0; r < ROWS; r++) begin
        for (int unsigned c = 0; c < COLS; c++) begin
          if (cap && (cap_row == ADDR_W'(r))) begin
            coeff_flat[(r*COLS+c)*CW +: CW] <= cap_cols[c];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_gauss_coeff_loader.sv
// Scoreboard bench: three loader instances (auto-load, manual start, 3-cycle ROM latency).
module tb_gauss_coeff_loader;
  import gauss_pkg::*;

  localparam int FW = ROWS * COLS * CW;

  typedef struct {
    int               cyc;
    logic [SUM_W-1:0] sum;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];
  exp_t ea, eb, ec;

  // Default ROM image; byte 4 (MSB) is column 0
  logic [WORD_W-1:0] rom_img [ROWS] = '{
    40'h0103060402,
    40'h040C100C04,
    40'h0410201004,
    40'h040C100C04,
    40'h0204060301
  };
  logic [7:0] kern [ROWS][COLS] = '{
    '{8'h01, 8'h03, 8'h06, 8'h04, 8'h02},
    '{8'h04, 8'h0C, 8'h10, 8'h0C, 8'h04},
    '{8'h04, 8'h10, 8'h20, 8'h10, 8'h04},
    '{8'h04, 8'h0C, 8'h10, 8'h0C, 8'h04},
    '{8'h02, 8'h04, 8'h06, 8'h03, 8'h01}
  };
  logic [FW-1:0] exp_flat;

  logic rst_a, rst_b, rst_c;
  logic start_a, start_b, start_c;
  logic busy_a, busy_b, busy_c;
  logic done_a, done_b, done_c;
  logic valid_a, valid_b, valid_c;
  logic [FW-1:0] flat_a, flat_b, flat_c;
  logic [SUM_W-1:0] sum_a, sum_b, sum_c;

  gauss_coeff_loader_if bus_a ();
  gauss_coeff_loader_if bus_b ();
  gauss_coeff_loader_if bus_c ();

  gauss_coeff_loader #(.ROM_LAT(1), .AUTO_LOAD(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_a), .start(start_a), .busy(busy_a), .done(done_a),
    .coeff_valid(valid_a), .rom(bus_a.master), .coeff_flat(flat_a), .coeff_sum(sum_a));
  gauss_coeff_loader #(.ROM_LAT(1), .AUTO_LOAD(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_b), .start(start_b), .busy(busy_b), .done(done_b),
    .coeff_valid(valid_b), .rom(bus_b.master), .coeff_flat(flat_b), .coeff_sum(sum_b));
  gauss_coeff_loader #(.ROM_LAT(3), .AUTO_LOAD(1'b0)) dut_c (
    .clk(clk), .rst_n(rst_c), .start(start_c), .busy(busy_c), .done(done_c),
    .coeff_valid(valid_c), .rom(bus_c.master), .coeff_flat(flat_c), .coeff_sum(sum_c));

  // ROM models; unread cycles return all-ones so a mistimed capture corrupts the bank
  logic [WORD_W-1:0] da;
  logic [WORD_W-1:0] db;
  logic [WORD_W-1:0] dc [3];
  always @(posedge clk) begin
    da    <= bus_a.rom_rd_en ? rom_img[bus_a.rom_addr] : '1;
    db    <= bus_b.rom_rd_en ? rom_img[bus_b.rom_addr] : '1;
    dc[0] <= bus_c.rom_rd_en ? rom_img[bus_c.rom_addr] : '1;
    dc[1] <= dc[0];
    dc[2] <= dc[1];
  end
  assign bus_a.rom_data = da;
  assign bus_b.rom_data = db;
  assign bus_c.rom_data = dc[2];

  task automatic chk(input string nm, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_zero(input string t, input logic b, input logic d, input logic v,
                          input logic r, input logic [ADDR_W-1:0] a,
                          input logic [FW-1:0] f, input logic [SUM_W-1:0] s);
    chk({t, " busy"}, b, 0);
    chk({t, " done"}, d, 0);
    chk({t, " coeff_valid"}, v, 0);
    chk({t, " rom_rd_en"}, r, 0);
    chk({t, " rom_addr"}, a, 0);
    chk({t, " coeff_flat"}, f, 0);
    chk({t, " coeff_sum"}, s, 0);
  endtask

  // Read monitors: addresses must run 0,1,2,... within each burst
  int rd_a = 0, rd_b = 0, rd_c = 0, bz_b = 0;
  logic pv_a = 1'b0, pv_b = 1'b0, pv_c = 1'b0;
  logic [ADDR_W-1:0] pa_a, pa_b, pa_c;
  always @(negedge clk) begin
    if (bus_a.rom_rd_en) begin
      chk("A rom_addr seq", bus_a.rom_addr, pv_a ? pa_a + 3'd1 : 3'd0);
      rd_a++;
      pa_a = bus_a.rom_addr;
    end
    pv_a = bus_a.rom_rd_en;
    if (bus_b.rom_rd_en) begin
      chk("B rom_addr seq", bus_b.rom_addr, pv_b ? pa_b + 3'd1 : 3'd0);
      rd_b++;
      pa_b = bus_b.rom_addr;
    end
    pv_b = bus_b.rom_rd_en;
    if (bus_c.rom_rd_en) begin
      chk("C rom_addr seq", bus_c.rom_addr, pv_c ? pa_c + 3'd1 : 3'd0);
      rd_c++;
      pa_c = bus_c.rom_addr;
    end
    pv_c = bus_c.rom_rd_en;
    if (busy_b) bz_b++;
  end

  // Done monitors: pop the expected completion and check timing, then bank/sum a cycle later
  always @(negedge clk) if (done_a) begin
    if (qa.size() == 0) begin
      n_chk++; n_fail++;
      $display("FAIL A unexpected done: got done=1, expected none (cycle %0d)", cyc);
    end else begin
      ea = qa.pop_front();
      chk("A done cycle", cyc, ea.cyc);
      chk("A busy in DONE", busy_a, 0);
      @(negedge clk);
      chk("A coeff_sum", sum_a, ea.sum);
      chk("A coeff_flat", flat_a, exp_flat);
      chk("A coeff_valid", valid_a, 1);
    end
  end

  always @(negedge clk) if (done_b) begin
    if (qb.size() == 0) begin
      n_chk++; n_fail++;
      $display("FAIL B unexpected done: got done=1, expected none (cycle %0d)", cyc);
    end else begin
      eb = qb.pop_front();
      chk("B done cycle", cyc, eb.cyc);
      chk("B busy in DONE", busy_b, 0);
      @(negedge clk);
      chk("B coeff_sum", sum_b, eb.sum);
      chk("B coeff_flat", flat_b, exp_flat);
      chk("B coeff_valid", valid_b, 1);
    end
  end

  always @(negedge clk) if (done_c) begin
    if (qc.size() == 0) begin
      n_chk++; n_fail++;
      $display("FAIL C unexpected done: got done=1, expected none (cycle %0d)", cyc);
    end else begin
      ec = qc.pop_front();
      chk("C done cycle", cyc, ec.cyc);
      chk("C busy in DONE", busy_c, 0);
      @(negedge clk);
      chk("C coeff_sum", sum_c, ec.sum);
      chk("C coeff_flat", flat_c, exp_flat);
      chk("C coeff_valid", valid_c, 1);
    end
  end

  initial begin
    int c0, rb0, rc0, bb0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        exp_flat[(r*COLS+c)*CW +: CW] = kern[r][c];

    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("A reset", busy_a, done_a, valid_a, bus_a.rom_rd_en, bus_a.rom_addr, flat_a, sum_a);
    chk_zero("C reset", busy_c, done_c, valid_c, bus_c.rom_rd_en, bus_c.rom_addr, flat_c, sum_c);

    // Release all: A auto-loads, B and C wait for start
    @(negedge clk);
    qa.push_back('{cyc + 7, 13'd200});
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    repeat (100) @(negedge clk);
    chk("A reads auto-load", rd_a, 5);
    chk("A centre coeff", flat_a[12*8 +: 8], 8'h20);
    chk("A kernel[0][0]", flat_a[7:0], 8'h01);
    chk("B reads without start", rd_b, 0);
    chk("C reads without start", rd_c, 0);
    chk("B valid before load", valid_b, 0);

    // Single start pulse on B
    rb0 = rd_b; bb0 = bz_b; c0 = cyc;
    start_b = 1'b1;
    qb.push_back('{c0 + 7, 13'd200});
    @(negedge clk); start_b = 1'b0;
    repeat (15) @(negedge clk);
    chk("B busy cycles", bz_b - bb0, 6);
    chk("B reads per load", rd_b - rb0, 5);

    // Second start pulse in cycle 3 of the load is ignored
    rb0 = rd_b; c0 = cyc;
    start_b = 1'b1;
    qb.push_back('{c0 + 7, 13'd200});
    @(negedge clk); start_b = 1'b0;
    repeat (2) @(negedge clk);
    start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
    repeat (15) @(negedge clk);
    chk("B reads with start while busy", rd_b - rb0, 5);

    // Abort A during FETCH row 2, then let the post-reset auto-load run
    rst_a = 1'b0;
    @(negedge clk); rst_a = 1'b1;
    repeat (3) @(negedge clk);
    chk("A addr before abort", bus_a.rom_addr, 2);
    #2 rst_a = 1'b0;
    #1 chk_zero("A async abort", busy_a, done_a, valid_a, bus_a.rom_rd_en, bus_a.rom_addr, flat_a, sum_a);
    @(negedge clk);
    rst_a = 1'b1;
    qa.push_back('{cyc + 7, 13'd200});
    repeat (12) @(negedge clk);

    // C: start held high with 3-cycle ROM latency gives loads every 10 cycles
    rc0 = rd_c; c0 = cyc;
    start_c = 1'b1;
    for (int k = 0; k < 3; k++) qc.push_back('{c0 + 9 + 10*k, 13'd200});
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1 || k == 11 || k == 21) chk("C valid drops in FETCH", valid_c, 0);
      if (k == 21) start_c = 1'b0;
    end
    chk("C reads for 3 loads", rd_c - rc0, 15);

    chk("A pending completions", qa.size(), 0);
    chk("B pending completions", qb.size(), 0);
    chk("C pending completions", qc.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
